// File: rtl/base_skid_rst.sv
// base_skid_rst: two-entry valid/ready skid buffer with a programmable
// per-bit reset value. i_r, o_v, o_d and o_cnt are all driven from flops,
// so the o_r -> i_r path is broken and one transfer per cycle is sustained.
//
// state | meaning
// ------+-----------------------------------------------------------
// EMPTY | (main_v,skid_v)=(0,0): nothing held, o_d keeps last value
// ONE   | (1,0): main holds the head, skid free, i_r=1
// FULL  | (1,1): main holds head, skid holds next beat, i_r=0
// (0,1) | illegal; forced back to EMPTY if ever seen
module base_skid_rst #(
  parameter int width = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [width-1:0] rstv,
  input  logic             i_v,
  output logic             i_r,
  input  logic [width-1:0] i_d,
  output logic             o_v,
  input  logic             o_r,
  output logic [width-1:0] o_d,
  output logic [1:0]       o_cnt
);

  logic             main_v;
  logic             skid_v;
  logic [width-1:0] main_d;
  logic [width-1:0] skid_d;

  logic             main_v_nxt;
  logic             skid_v_nxt;
  logic             ld_main_in;
  logic             ld_main_skid;
  logic             ld_skid_in;
  logic             accept;
  logic             deliver;

  // handshake events use registered ready/valid only
  assign accept  = i_v & ~skid_v;
  assign deliver = main_v & o_r;

  // state and data registers; reset loads rstv into both data slots
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_d <= rstv;
      skid_d <= rstv;
    end else begin
      main_v <= main_v_nxt;
      skid_v <= skid_v_nxt;
      if (ld_main_in)
        main_d <= i_d;
      else if (ld_main_skid)
        main_d <= skid_d;
      if (ld_skid_in)
        skid_d <= i_d;
    end
  end

  // next-state and data-load selection from current occupancy and handshakes
  always_comb begin
    main_v_nxt   = main_v;
    skid_v_nxt   = skid_v;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid_in   = 1'b0;
    case ({main_v, skid_v})
      2'b00: begin
        if (accept) begin
          main_v_nxt = 1'b1;
          ld_main_in = 1'b1;
        end
      end
      2'b10: begin
        if (accept && deliver) begin
          ld_main_in = 1'b1;
        end else if (accept) begin
          skid_v_nxt = 1'b1;
          ld_skid_in = 1'b1;
        end else if (deliver) begin
          main_v_nxt = 1'b0;
        end
      end
      2'b11: begin
        // skid full means i_r is low, so only a delivery can happen here
        if (deliver) begin
          skid_v_nxt   = 1'b0;
          ld_main_skid = 1'b1;
        end
      end
      default: begin
        main_v_nxt = 1'b0;
        skid_v_nxt = 1'b0;
      end
    endcase
  end

  // outputs depend on registered state only
  always_comb begin
    i_r   = ~skid_v;
    o_v   = main_v;
    o_d   = main_d;
    o_cnt = {1'b0, main_v} + {1'b0, skid_v};
  end

endmodule

// File: doc/base_skid_rst.md
# base_skid_rst

Two-entry valid/ready skid buffer with a per-bit programmable reset value, async active-high reset. Sits between a producer and a consumer that both use the valid/ready handshake. It registers the data path and registers `i_r`, so there is no combinational path from `o_r` to `i_r`. It sustains one transfer per cycle. It is the consumer-facing counterpart of the codebase's reset-valued capture registers: it presents a registered, handshaken output instead of an unconditional capture.

## Interface
- `width`, default 1: data width in bits.

- `clk`  in  1  clock; all state changes on posedge.
- `reset`  in  1  asynchronous, active-high reset.
- `rstv`  in  width  reset value loaded into both data registers while `reset` is high; treated as quasi-static.
- `i_v`  in  1  producer valid.
- `i_r`  out  1  ready to producer.
- `i_d`  in  width  producer data.
- `o_v`  out  1  valid to consumer.
- `o_r`  in  1  consumer ready.
- `o_d`  out  width  consumer data.
- `o_cnt`  out  2  occupancy: 0, 1 or 2 entries.

## Operation
- Storage is a main register (`main_v`, `main_d`, which drive `o_v` and `o_d`) and a skid register (`skid_v`, `skid_d`).
- State is encoded by the (`main_v`, `skid_v`) pair:
  - EMPTY = (0,0)
  - ONE = (1,0)
  - FULL = (1,1)
  - (0,1) is illegal and must never occur.
- Output mapping:
  - `i_r` = ~`skid_v`, a function of registered state only.
  - `o_v` = `main_v`.
  - `o_cnt` = `main_v` + `skid_v`.
- Handshake rules:
  - Accept = `i_v & i_r`.
  - Deliver = `o_v & o_r`.
  - `i_d` is sampled only on accept.
  - `i_v`, `i_d`, `o_r` are don't-care outside these events.
- Transitions, evaluated at posedge:
  - EMPTY, accept: `main_d` <= `i_d`; go to ONE.
  - EMPTY, no accept: hold.
  - ONE, accept and deliver: `main_d` <= `i_d`; stay in ONE.
  - ONE, accept and no deliver: `skid_d` <= `i_d`; go to FULL.
  - ONE, deliver and no accept: go to EMPTY; `main_d` holds its last value.
  - ONE, neither: hold.
  - FULL: `i_r` is 0, so no accept is possible.
  - FULL, deliver: `main_d` <= `skid_d`; go to ONE.
  - FULL, no deliver: hold.
- Ordering: strict FIFO. No data is duplicated or dropped.
- `o_d` is stable while `o_v` = 1 and `o_r` = 0.
- When `o_v` = 0, `o_d` holds its last loaded value; after reset that value is `rstv`.
- Reset, asynchronous, effective immediately and also mid-transfer:
  - `main_v` = 0, `skid_v` = 0.
  - `main_d` = `rstv`, `skid_d` = `rstv`.
  - Resulting outputs: `o_v` = 0, `i_r` = 1, `o_d` = `rstv`, `o_cnt` = 0.
  - In-flight data is discarded.
  - Handshakes during reset are ignored.

## Timing
- Latency: data accepted at edge N appears on `o_d` with `o_v` = 1 after edge N (visible in cycle N+1) when the buffer was EMPTY.
- Throughput: 1 transfer per cycle in steady state when `o_r` stays 1.
- Back-pressure:
  - `o_r` falling while in ONE with `i_v` = 1 fills the skid; `i_r` drops in the following cycle.
  - At most one beat is absorbed after `o_r` falls.
- Recovery: from FULL, one deliver edge returns to ONE and raises `i_r` for the next cycle.
- Simultaneous accept and deliver in FULL cannot occur, because `i_r` = 0.
- Reset release: the first accept can occur at the first posedge after `reset` deasserts.
- All outputs are flop-driven, or depend on flops only. No input-to-output combinational path exists.

## Test plan
- Reset values: `width`=8, `rstv`=8'hA5, assert `reset` asynchronously mid-cycle -> immediately `o_v`=0, `i_r`=1, `o_d`=8'hA5, `o_cnt`=0; no posedge needed.
- Streaming: `o_r`=1, `i_v`=1 with `i_d`=1,2,3,… on consecutive cycles -> `o_d`=1,2,3,… one cycle later, `o_v` held at 1, `o_cnt`=1, `i_r` always 1.
- Back-pressure fill and drain:
  - Stimulus: stream 10,11,12 with `o_r`=0 from the second edge.
  - Required fill: `o_d`=10 held stable, `o_cnt` reaches 2, `i_r`=0, 12 is not accepted.
  - Required drain after raising `o_r`: outputs 10, 11, then 12 after re-accept, in order.
- Drain to empty: a single beat 8'h3C, then `i_v`=0 with `o_r`=1 -> `o_v` falls after one delivery, `o_d` stays 8'h3C, `o_cnt`=0.
- Reset mid-operation: in FULL holding 20,21, assert `reset` -> both entries lost, `o_d`=`rstv`, `o_cnt`=0; after release, new beat 22 is delivered first.
- Randomized: random `i_v`/`o_r` for 10k cycles against a scoreboard -> no loss, duplication or reorder; `o_d` stable under stall; (`main_v`,`skid_v`) never equals (0,1).
